// File: rtl/mips_pkg.sv
// Shared MIPS32 encoding constants: mnemonic enum, opcode/funct fields and packing helpers.
// Used by both the control decoder and the instruction encoder.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_ADD   = 6'd0,  OP_ADDU  = 6'd1,  OP_SUB   = 6'd2,  OP_SUBU  = 6'd3,
        OP_AND   = 6'd4,  OP_OR    = 6'd5,  OP_XOR   = 6'd6,  OP_NOR   = 6'd7,
        OP_SLT   = 6'd8,  OP_SLTU  = 6'd9,  OP_SLL   = 6'd10, OP_SRL   = 6'd11,
        OP_SRA   = 6'd12, OP_SLLV  = 6'd13, OP_SRLV  = 6'd14, OP_SRAV  = 6'd15,
        OP_ROTR  = 6'd16, OP_ROTRV = 6'd17, OP_JR    = 6'd18, OP_MUL   = 6'd19,
        OP_MADD  = 6'd20, OP_MSUB  = 6'd21, OP_SEB   = 6'd22, OP_SEH   = 6'd23,
        OP_ADDI  = 6'd24, OP_ADDIU = 6'd25, OP_SLTI  = 6'd26, OP_SLTIU = 6'd27,
        OP_ANDI  = 6'd28, OP_ORI   = 6'd29, OP_XORI  = 6'd30, OP_LUI   = 6'd31,
        OP_LB    = 6'd32, OP_LH    = 6'd33, OP_LW    = 6'd34, OP_LBU   = 6'd35,
        OP_LHU   = 6'd36, OP_SB    = 6'd37, OP_SH    = 6'd38, OP_SW    = 6'd39,
        OP_BEQ   = 6'd40, OP_BNE   = 6'd41, OP_BGTZ  = 6'd42, OP_BLEZ  = 6'd43,
        OP_BGEZ  = 6'd44, OP_BLTZ  = 6'd45, OP_J     = 6'd46, OP_JAL   = 6'd47,
        OP_LI    = 6'd48
    } op_e;

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} enc_state_e;

    localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
    localparam logic [5:0] OPC_REGIMM   = 6'b000001;
    localparam logic [5:0] OPC_J        = 6'b000010;
    localparam logic [5:0] OPC_JAL      = 6'b000011;
    localparam logic [5:0] OPC_BEQ      = 6'b000100;
    localparam logic [5:0] OPC_BNE      = 6'b000101;
    localparam logic [5:0] OPC_BLEZ     = 6'b000110;
    localparam logic [5:0] OPC_BGTZ     = 6'b000111;
    localparam logic [5:0] OPC_ADDI     = 6'b001000;
    localparam logic [5:0] OPC_ADDIU    = 6'b001001;
    localparam logic [5:0] OPC_SLTI     = 6'b001010;
    localparam logic [5:0] OPC_SLTIU    = 6'b001011;
    localparam logic [5:0] OPC_ANDI     = 6'b001100;
    localparam logic [5:0] OPC_ORI      = 6'b001101;
    localparam logic [5:0] OPC_XORI     = 6'b001110;
    localparam logic [5:0] OPC_LUI      = 6'b001111;
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OPC_SPECIAL3 = 6'b011111;
    localparam logic [5:0] OPC_LB       = 6'b100000;
    localparam logic [5:0] OPC_LH       = 6'b100001;
    localparam logic [5:0] OPC_LW       = 6'b100011;
    localparam logic [5:0] OPC_LBU      = 6'b100100;
    localparam logic [5:0] OPC_LHU      = 6'b100101;
    localparam logic [5:0] OPC_SB       = 6'b101000;
    localparam logic [5:0] OPC_SH       = 6'b101001;
    localparam logic [5:0] OPC_SW       = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [5:0] FN2_MADD  = 6'b000000;
    localparam logic [5:0] FN2_MUL   = 6'b000010;
    localparam logic [5:0] FN2_MSUB  = 6'b000100;
    localparam logic [5:0] FN3_BSHFL = 6'b100000;
    localparam logic [4:0] SA_SEB    = 5'b10000;
    localparam logic [4:0] SA_SEH    = 5'b11000;
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] pack_r(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                           logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
        return {opc, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] pack_i(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                           logic [15:0] imm16);
        return {opc, rs, rt, imm16};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/emit bundle between a symbolic-instruction source and the encoder.
interface instr_encoder_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [31:0]       imm;
    logic [25:0]       target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    modport master (output in_valid, op, rs, rt, rd, shamt, imm, target, out_ready,
                    input  in_ready, out_valid, out_instr, out_addr, err);
    modport slave  (input  in_valid, op, rs, rt, rd, shamt, imm, target, out_ready,
                    output in_ready, out_valid, out_instr, out_addr, err);
endinterface

// File: rtl/instr_pack.sv
// Combinational mnemonic-to-machine-word mapping; fields an op does not define are zeroed.
module instr_pack
    import mips_pkg::*;
#(
    parameter int DELAY_SLOT_NOP = 1
) (
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word1,
    output logic [31:0] word2,
    output logic        has_word2,
    output logic        illegal
);
    logic [15:0] imm_lo;
    logic [15:0] imm_hi;
    logic        is_ctrl;

    assign imm_lo = imm[15:0];
    assign imm_hi = imm[31:16];

    always_comb begin
        word1     = NOP_WORD;
        word2     = NOP_WORD;
        has_word2 = 1'b0;
        illegal   = 1'b0;
        is_ctrl   = 1'b0;
        case (op)
            OP_ADD:   word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_ADD);
            OP_ADDU:  word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_ADDU);
            OP_SUB:   word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SUB);
            OP_SUBU:  word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SUBU);
            OP_AND:   word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_AND);
            OP_OR:    word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_OR);
            OP_XOR:   word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_XOR);
            OP_NOR:   word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_NOR);
            OP_SLT:   word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SLT);
            OP_SLTU:  word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SLTU);
            OP_SLL:   word1 = pack_r(OPC_SPECIAL, 5'd0, rt, rd, shamt, FN_SLL);
            OP_SRL:   word1 = pack_r(OPC_SPECIAL, 5'd0, rt, rd, shamt, FN_SRL);
            OP_SRA:   word1 = pack_r(OPC_SPECIAL, 5'd0, rt, rd, shamt, FN_SRA);
            // Rotates reuse the SRL/SRLV functs, distinguished by a 1 in rs or shamt
            OP_ROTR:  word1 = pack_r(OPC_SPECIAL, 5'd1, rt, rd, shamt, FN_SRL);
            OP_SLLV:  word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SLLV);
            OP_SRLV:  word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SRLV);
            OP_SRAV:  word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SRAV);
            OP_ROTRV: word1 = pack_r(OPC_SPECIAL, rs, rt, rd, 5'd1, FN_SRLV);
            OP_JR: begin
                word1   = pack_r(OPC_SPECIAL, rs, 5'd0, 5'd0, 5'd0, FN_JR);
                is_ctrl = 1'b1;
            end
            OP_MUL:   word1 = pack_r(OPC_SPECIAL2, rs, rt, rd, 5'd0, FN2_MUL);
            OP_MADD:  word1 = pack_r(OPC_SPECIAL2, rs, rt, 5'd0, 5'd0, FN2_MADD);
            OP_MSUB:  word1 = pack_r(OPC_SPECIAL2, rs, rt, 5'd0, 5'd0, FN2_MSUB);
            OP_SEB:   word1 = pack_r(OPC_SPECIAL3, 5'd0, rt, rd, SA_SEB, FN3_BSHFL);
            OP_SEH:   word1 = pack_r(OPC_SPECIAL3, 5'd0, rt, rd, SA_SEH, FN3_BSHFL);
            OP_ADDI:  word1 = pack_i(OPC_ADDI, rs, rt, imm_lo);
            OP_ADDIU: word1 = pack_i(OPC_ADDIU, rs, rt, imm_lo);
            OP_SLTI:  word1 = pack_i(OPC_SLTI, rs, rt, imm_lo);
            OP_SLTIU: word1 = pack_i(OPC_SLTIU, rs, rt, imm_lo);
            OP_ANDI:  word1 = pack_i(OPC_ANDI, rs, rt, imm_lo);
            OP_ORI:   word1 = pack_i(OPC_ORI, rs, rt, imm_lo);
            OP_XORI:  word1 = pack_i(OPC_XORI, rs, rt, imm_lo);
            OP_LUI:   word1 = pack_i(OPC_LUI, 5'd0, rt, imm_lo);
            OP_LB:    word1 = pack_i(OPC_LB, rs, rt, imm_lo);
            OP_LH:    word1 = pack_i(OPC_LH, rs, rt, imm_lo);
            OP_LW:    word1 = pack_i(OPC_LW, rs, rt, imm_lo);
            OP_LBU:   word1 = pack_i(OPC_LBU, rs, rt, imm_lo);
            OP_LHU:   word1 = pack_i(OPC_LHU, rs, rt, imm_lo);
            OP_SB:    word1 = pack_i(OPC_SB, rs, rt, imm_lo);
            OP_SH:    word1 = pack_i(OPC_SH, rs, rt, imm_lo);
            OP_SW:    word1 = pack_i(OPC_SW, rs, rt, imm_lo);
            OP_BEQ:  begin word1 = pack_i(OPC_BEQ, rs, rt, imm_lo);         is_ctrl = 1'b1; end
            OP_BNE:  begin word1 = pack_i(OPC_BNE, rs, rt, imm_lo);         is_ctrl = 1'b1; end
            OP_BGTZ: begin word1 = pack_i(OPC_BGTZ, rs, 5'd0, imm_lo);      is_ctrl = 1'b1; end
            OP_BLEZ: begin word1 = pack_i(OPC_BLEZ, rs, 5'd0, imm_lo);      is_ctrl = 1'b1; end
            OP_BGEZ: begin word1 = pack_i(OPC_REGIMM, rs, RT_BGEZ, imm_lo); is_ctrl = 1'b1; end
            OP_BLTZ: begin word1 = pack_i(OPC_REGIMM, rs, RT_BLTZ, imm_lo); is_ctrl = 1'b1; end
            OP_J:    begin word1 = {OPC_J, target};                         is_ctrl = 1'b1; end
            OP_JAL:  begin word1 = {OPC_JAL, target};                       is_ctrl = 1'b1; end
            OP_LI: begin
                // A constant that fits in 16 bits needs only the ORI from $0
                if (imm_hi != 16'd0) begin
                    word1     = pack_i(OPC_LUI, 5'd0, rt, imm_hi);
                    word2     = pack_i(OPC_ORI, rt, rt, imm_lo);
                    has_word2 = 1'b1;
                end else begin
                    word1 = pack_i(OPC_ORI, 5'd0, rt, imm_lo);
                end
            end
            default: illegal = 1'b1;
        endcase
        if (is_ctrl && (DELAY_SLOT_NOP != 0)) begin
            has_word2 = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: accepts symbolic requests, emits up to two
// packed words per request with a running byte address.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int BASE_ADDR      = 0,
    parameter int DELAY_SLOT_NOP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    enc_state_e        state_reg, state_next;
    logic [31:0]       out_instr_reg, out_instr_next;
    logic [31:0]       word2_reg, word2_next;
    logic              has_word2_reg, has_word2_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              err_reg, err_next;

    logic [31:0]       pk_word1;
    logic [31:0]       pk_word2;
    logic              pk_has_word2;
    logic              pk_illegal;

    instr_pack #(.DELAY_SLOT_NOP(DELAY_SLOT_NOP)) u_pack (
        .op        (bus.op),
        .rs        (bus.rs),
        .rt        (bus.rt),
        .rd        (bus.rd),
        .shamt     (bus.shamt),
        .imm       (bus.imm),
        .target    (bus.target),
        .word1     (pk_word1),
        .word2     (pk_word2),
        .has_word2 (pk_has_word2),
        .illegal   (pk_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_instr_reg <= NOP_WORD;
            word2_reg     <= NOP_WORD;
            has_word2_reg <= 1'b0;
            addr_reg      <= BASE;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_instr_reg <= out_instr_next;
            word2_reg     <= word2_next;
            has_word2_reg <= has_word2_next;
            addr_reg      <= addr_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        out_instr_next = out_instr_reg;
        word2_next     = word2_reg;
        has_word2_next = has_word2_reg;
        addr_next      = addr_reg;
        err_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    word2_next     = pk_word2;
                    has_word2_next = pk_has_word2;
                    // Unknown ops only raise err; the output word and address stay put
                    if (pk_illegal) begin
                        err_next = 1'b1;
                    end else begin
                        out_instr_next = pk_word1;
                        state_next     = EMIT1;
                    end
                end
            end
            EMIT1: begin
                if (bus.out_ready) begin
                    addr_next = addr_reg + STEP;
                    if (has_word2_reg) begin
                        out_instr_next = word2_reg;
                        state_next     = EMIT2;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            EMIT2: begin
                if (bus.out_ready) begin
                    addr_next  = addr_reg + STEP;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == EMIT1) || (state_reg == EMIT2);
    assign bus.out_instr = out_instr_reg;
    assign bus.out_addr  = addr_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Drives three encoder configurations in lockstep (default, no delay-slot NOP with
// a non-zero base, 4-bit address) and checks every emitted word against a model.
module tb_instr_encoder;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [5:0]  op_d;
    logic [4:0]  rs_d, rt_d, rd_d, sh_d;
    logic [31:0] imm_d;
    logic [25:0] tgt_d;
    logic        out_ready;

    logic [2:0]  ov, ir, er;
    logic [31:0] oi [3];
    logic [31:0] oa [3];

    int          tests = 0;
    int          fails = 0;
    logic [31:0] base_a [3] = '{32'd0, 32'd64, 32'd0};
    logic [31:0] mask_a [3] = '{32'd1023, 32'd1023, 32'd15};
    logic [31:0] addr_exp [3];
    logic [31:0] cap_w [3][2];
    logic [31:0] cap_a [3][2];
    int          cap_n [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int AWI  = (gi == 2) ? 4 : 10;
        localparam int BASE = (gi == 1) ? 64 : 0;
        localparam int NOPI = (gi == 1) ? 0 : 1;
        instr_encoder_if #(.ADDR_W(AWI)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.op        = op_d;
        assign bus.rs        = rs_d;
        assign bus.rt        = rt_d;
        assign bus.rd        = rd_d;
        assign bus.shamt     = sh_d;
        assign bus.imm       = imm_d;
        assign bus.target    = tgt_d;
        assign bus.out_ready = out_ready;
        instr_encoder #(.ADDR_W(AWI), .BASE_ADDR(BASE), .DELAY_SLOT_NOP(NOPI)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
        assign ov[gi] = bus.out_valid;
        assign ir[gi] = bus.in_ready;
        assign er[gi] = bus.err;
        assign oi[gi] = bus.out_instr;
        assign oa[gi] = 32'(bus.out_addr);
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%08h expected=%08h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [31:0] rw(logic [31:0] opc, logic [31:0] s, logic [31:0] t,
                                       logic [31:0] d, logic [31:0] sh, logic [31:0] fn);
        return (opc << 26) | (s << 21) | (t << 16) | (d << 11) | (sh << 6) | fn;
    endfunction

    function automatic logic [31:0] iw(logic [31:0] opc, logic [31:0] s, logic [31:0] t, logic [31:0] im);
        return (opc << 26) | (s << 21) | (t << 16) | (im & 32'hFFFF);
    endfunction

    // Reference encoding straight from the MIPS32 field tables.
    task automatic model(input logic [5:0] op, input logic [31:0] s, input logic [31:0] t,
                         input logic [31:0] d, input logic [31:0] sh, input logic [31:0] im,
                         input logic [31:0] tg, input bit nop_en,
                         output logic [31:0] w1, output logic [31:0] w2, output int n, output bit bad);
        bit ctl;
        ctl = 0; bad = 0; n = 1; w1 = 0; w2 = 0;
        case (op)
            OP_ADD:   w1 = rw(0, s, t, d, 0, 'h20);
            OP_ADDU:  w1 = rw(0, s, t, d, 0, 'h21);
            OP_SUB:   w1 = rw(0, s, t, d, 0, 'h22);
            OP_SUBU:  w1 = rw(0, s, t, d, 0, 'h23);
            OP_AND:   w1 = rw(0, s, t, d, 0, 'h24);
            OP_OR:    w1 = rw(0, s, t, d, 0, 'h25);
            OP_XOR:   w1 = rw(0, s, t, d, 0, 'h26);
            OP_NOR:   w1 = rw(0, s, t, d, 0, 'h27);
            OP_SLT:   w1 = rw(0, s, t, d, 0, 'h2A);
            OP_SLTU:  w1 = rw(0, s, t, d, 0, 'h2B);
            OP_SLL:   w1 = rw(0, 0, t, d, sh, 'h00);
            OP_SRL:   w1 = rw(0, 0, t, d, sh, 'h02);
            OP_SRA:   w1 = rw(0, 0, t, d, sh, 'h03);
            OP_ROTR:  w1 = rw(0, 0, t, d, sh, 'h02) | 32'h0020_0000;
            OP_SLLV:  w1 = rw(0, s, t, d, 0, 'h04);
            OP_SRLV:  w1 = rw(0, s, t, d, 0, 'h06);
            OP_SRAV:  w1 = rw(0, s, t, d, 0, 'h07);
            OP_ROTRV: w1 = rw(0, s, t, d, 0, 'h06) | 32'h0000_0040;
            OP_JR:    begin w1 = rw(0, s, 0, 0, 0, 'h08); ctl = 1; end
            OP_MUL:   w1 = rw('h1C, s, t, d, 0, 'h02);
            OP_MADD:  w1 = rw('h1C, s, t, 0, 0, 'h00);
            OP_MSUB:  w1 = rw('h1C, s, t, 0, 0, 'h04);
            OP_SEB:   w1 = rw('h1F, 0, t, d, 'h10, 'h20);
            OP_SEH:   w1 = rw('h1F, 0, t, d, 'h18, 'h20);
            OP_ADDI:  w1 = iw('h08, s, t, im);
            OP_ADDIU: w1 = iw('h09, s, t, im);
            OP_SLTI:  w1 = iw('h0A, s, t, im);
            OP_SLTIU: w1 = iw('h0B, s, t, im);
            OP_ANDI:  w1 = iw('h0C, s, t, im);
            OP_ORI:   w1 = iw('h0D, s, t, im);
            OP_XORI:  w1 = iw('h0E, s, t, im);
            OP_LUI:   w1 = iw('h0F, 0, t, im);
            OP_LB:    w1 = iw('h20, s, t, im);
            OP_LH:    w1 = iw('h21, s, t, im);
            OP_LW:    w1 = iw('h23, s, t, im);
            OP_LBU:   w1 = iw('h24, s, t, im);
            OP_LHU:   w1 = iw('h25, s, t, im);
            OP_SB:    w1 = iw('h28, s, t, im);
            OP_SH:    w1 = iw('h29, s, t, im);
            OP_SW:    w1 = iw('h2B, s, t, im);
            OP_BEQ:   begin w1 = iw('h04, s, t, im); ctl = 1; end
            OP_BNE:   begin w1 = iw('h05, s, t, im); ctl = 1; end
            OP_BGTZ:  begin w1 = iw('h07, s, 0, im); ctl = 1; end
            OP_BLEZ:  begin w1 = iw('h06, s, 0, im); ctl = 1; end
            OP_BGEZ:  begin w1 = iw('h01, s, 1, im); ctl = 1; end
            OP_BLTZ:  begin w1 = iw('h01, s, 0, im); ctl = 1; end
            OP_J:     begin w1 = (32'h2 << 26) | tg; ctl = 1; end
            OP_JAL:   begin w1 = (32'h3 << 26) | tg; ctl = 1; end
            OP_LI: begin
                if ((im >> 16) != 0) begin
                    w1 = iw('h0F, 0, t, im >> 16);
                    w2 = iw('h0D, t, t, im);
                    n  = 2;
                end else begin
                    w1 = iw('h0D, 0, t, im);
                end
            end
            default: begin bad = 1; n = 0; end
        endcase
        if (ctl && nop_en) n = 2;
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, 32'(ov[k]), 0);
            chk("rst_ready", k, 32'(ir[k]), 1);
            chk("rst_err",   k, 32'(er[k]), 0);
            chk("rst_instr", k, oi[k], 0);
            chk("rst_addr",  k, oa[k], base_a[k]);
            addr_exp[k] = base_a[k];
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One request presented to all three encoders; each output stream is followed to completion.
    task automatic do_req(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, input logic [4:0] sh, input logic [31:0] im,
                          input logic [25:0] tg, input int stall, input bit rnd);
        logic [31:0] ew [3][2];
        int          en [3];
        bit          bad [3];
        int          idx [3];
        int          cyc;
        for (int k = 0; k < 3; k++) begin
            model(op, 32'(s), 32'(t), 32'(d), 32'(sh), im, 32'(tg), k != 1,
                  ew[k][0], ew[k][1], en[k], bad[k]);
            idx[k] = 0; cap_n[k] = 0;
        end
        chk("idle_before", -1, 32'(ir), 32'h7);
        in_valid = 1'b1; op_d = op; rs_d = s; rt_d = t; rd_d = d; sh_d = sh; imm_d = im; tgt_d = tg;
        @(negedge clk);
        in_valid = 1'b0; op_d = 6'($urandom); rs_d = 5'($urandom); rt_d = 5'($urandom);
        rd_d = 5'($urandom); sh_d = 5'($urandom); imm_d = $urandom; tgt_d = 26'($urandom);
        $display("[TB] txn op=%0d words=%0d/%0d/%0d", op, en[0], en[1], en[2]);
        if (bad[0]) begin
            chk("err_pulse",  -1, 32'(er), 32'h7);
            chk("err_novalid", -1, 32'(ov), 0);
            chk("err_ready",  -1, 32'(ir), 32'h7);
            @(negedge clk);
            chk("err_clear",  -1, 32'(er), 0);
            chk("err_novalid2", -1, 32'(ov), 0);
        end else begin
            cyc = 0;
            while ((idx[0] < en[0] || idx[1] < en[1] || idx[2] < en[2]) && cyc < 64) begin
                out_ready = (cyc < stall) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
                for (int k = 0; k < 3; k++) begin
                    if (idx[k] < en[k]) begin
                        chk("valid", k, 32'(ov[k]), 1);
                        chk("in_ready_low", k, 32'(ir[k]), 0);
                        chk("err_low", k, 32'(er[k]), 0);
                        chk("instr", k, oi[k], ew[k][idx[k]]);
                        chk("addr", k, oa[k], addr_exp[k]);
                        if (out_ready) begin
                            cap_w[k][idx[k]] = oi[k];
                            cap_a[k][idx[k]] = oa[k];
                            cap_n[k]++;
                            idx[k]++;
                            addr_exp[k] = (addr_exp[k] + 4) & mask_a[k];
                        end
                    end else begin
                        chk("idle_valid", k, 32'(ov[k]), 0);
                        chk("idle_ready", k, 32'(ir[k]), 1);
                    end
                end
                cyc++;
                @(negedge clk);
            end
            chk("emit_timeout", -1, 32'(cyc < 64), 1);
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                chk("done_valid", k, 32'(ov[k]), 0);
                chk("done_ready", k, 32'(ir[k]), 1);
            end
        end
    endtask

    initial begin
        logic [5:0]  rop;
        logic [31:0] rimm;
        logic [31:0] wrap_a [5];
        in_valid = 1'b0; out_ready = 1'b0; op_d = '0; rs_d = '0; rt_d = '0; rd_d = '0;
        sh_d = '0; imm_d = '0; tgt_d = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("por_valid", k, 32'(ov[k]), 0);
            chk("por_ready", k, 32'(ir[k]), 1);
            chk("por_instr", k, oi[k], 0);
            chk("por_addr",  k, oa[k], base_a[k]);
            chk("por_err",   k, 32'(er[k]), 0);
            addr_exp[k] = base_a[k];
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 26'd0, 0, 1'b0);
        chk("add_word", 0, cap_w[0][0], 32'h0022_1820);
        chk("add_addr", 0, cap_a[0][0], 32'h0);

        reset_all();
        do_req(OP_LI, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678, 26'd0, 0, 1'b0);
        chk("li_w1", 0, cap_w[0][0], 32'h3C08_1234);
        chk("li_w2", 0, cap_w[0][1], 32'h3508_5678);
        chk("li_a2", 0, cap_a[0][1], 32'h4);

        reset_all();
        do_req(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 32'd3, 26'd0, 3, 1'b0);
        chk("beq_w1", 0, cap_w[0][0], 32'h1022_0003);
        chk("beq_nop", 0, cap_w[0][1], 32'h0);
        chk("beq_nop_addr", 0, cap_a[0][1], 32'h4);
        chk("beq_nonop_count", 1, 32'(cap_n[1]), 1);

        do_req(OP_ROTR, 5'd0, 5'd3, 5'd2, 5'd4, 32'd0, 26'd0, 0, 1'b0);
        chk("rotr_word", 0, cap_w[0][0], 32'h0023_1102);
        do_req(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'h100, 0, 1'b0);
        chk("j_word", 0, cap_w[0][0], 32'h0800_0100);

        reset_all();
        do_req(6'd60, 5'd1, 5'd2, 5'd3, 5'd4, 32'd5, 26'd6, 0, 1'b0);
        do_req(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 26'd0, 0, 1'b0);
        chk("after_err_addr", 0, cap_a[0][0], 32'h0);

        reset_all();
        for (int i = 0; i < 5; i++) begin
            do_req(OP_ADD, 5'(i), 5'd2, 5'd3, 5'd0, 32'd0, 26'd0, 0, 1'b0);
            wrap_a[i] = cap_a[2][0];
        end
        for (int i = 0; i < 5; i++) chk("wrap_addr", 2, wrap_a[i], 32'((4 * i) % 16));

        // Reset while the second LI word is pending
        reset_all();
        in_valid = 1'b1; op_d = OP_LI; rt_d = 5'd8; imm_d = 32'h1234_5678; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_emit1", 0, oi[0], 32'h3C08_1234);
        @(negedge clk);
        chk("mid_emit2_valid", -1, 32'(ov), 32'h7);
        chk("mid_emit2", 0, oi[0], 32'h3508_5678);
        #2 rst_n = 1'b0;
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("abort_valid", k, 32'(ov[k]), 0);
            chk("abort_addr", k, oa[k], base_a[k]);
            addr_exp[k] = base_a[k];
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(OP_ADD, 5'd7, 5'd8, 5'd9, 5'd0, 32'd0, 26'd0, 0, 1'b0);
        chk("after_abort_addr", 1, cap_a[1][0], 32'd64);

        for (int i = 0; i < 150; i++) begin
            rop  = ($urandom_range(0, 9) == 0) ? 6'(49 + $urandom_range(0, 14)) : 6'($urandom_range(0, 48));
            rimm = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & 32'hFFFF);
            do_req(rop, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rimm,
                   26'($urandom), int'($urandom_range(0, 2)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS32 instruction encoder and program-image writer, the inverse of the pipeline's control decoder. It accepts symbolic instruction requests (mnemonic plus register, shift, immediate and target fields) over a valid/ready handshake. It emits packed 32-bit instruction words with a running word address to instruction-memory preload logic or a trace checker. It expands the `LI` pseudo-op into two words and optionally appends a delay-slot NOP after branches and jumps.

## Interface
- `ADDR_W`, default 10: width of the emitted byte address; wraps modulo 2^ADDR_W.
- `BASE_ADDR`, default 0: address of the first emitted word after reset. Must be a multiple of 4.
- `DELAY_SLOT_NOP`, default 1: when 1, a `0x00000000` word follows every branch, J, JAL and JR.
- `Clk`, in, 1: single clock, rising edge.
- `Rst`, in, 1: reset, asynchronous, active-low.
- `In_Valid`, in, 1: request present.
- `In_Ready`, out, 1: encoder can accept a request.
- `Op`, in, 6: mnemonic code from the shared package enum.
- `Rs`, `Rt`, `Rd`, `Shamt`, in, 5 each: register and shift fields.
- `Imm`, in, 32: immediate. Bits [15:0] are used, except that `LI` uses all 32 bits.
- `Target`, in, 26: jump target field.
- `Out_Valid`, out, 1: emitted word valid.
- `Out_Ready`, in, 1: sink accepts the word.
- `Out_Instr`, out, 32: encoded instruction word.
- `Out_Addr`, out, ADDR_W: byte address of `Out_Instr`.
- `Err`, out, 1: one-cycle pulse when an unknown `Op` is accepted.

## Operation
- The FSM has three states: `IDLE`, `EMIT1`, `EMIT2`. `In_Ready` = (state == `IDLE`).
- Accept: `In_Valid && In_Ready`. On accept, encode combinationally from the inputs and register the result.
  - Valid `Op`: register word 1 into `Out_Instr` and go to `EMIT1`.
  - Unknown `Op`: pulse `Err` the next cycle, stay in `IDLE`, emit nothing, leave the address unchanged.
- Each accept also latches a second-word flag and the second word:
  - `LI` with `Imm[31:16] != 0`: word 1 = `LUI rt,Imm[31:16]`; word 2 = `ORI rt,rt,Imm[15:0]`.
  - `LI` with `Imm[31:16] == 0`: a single word, `ORI rt,$0,Imm[15:0]`.
  - BEQ, BNE, BGTZ, BLEZ, BGEZ, BLTZ, J, JAL, JR when `DELAY_SLOT_NOP` = 1: word 2 = `0x00000000`.
  - All other ops: no second word.
- `EMIT1` and `EMIT2`: `Out_Valid` = 1, and `Out_Instr` and `Out_Addr` are held stable until `Out_Ready`.
  - On the handshake, `Out_Addr` increments by 4.
  - From `EMIT1`: go to `EMIT2` (loading word 2) if the flag is set, else to `IDLE`.
  - From `EMIT2`: go to `IDLE`.
- Field packing:
  - R-type: `{6'b000000, rs, rt, rd, shamt, funct}`.
  - SPECIAL2 (MUL, MADD, MSUB): opcode `011100`.
  - I-type: `{op, rs, rt, imm16}`.
  - J-type: `{op, target}`.
  - ROTR: sets bit 21 (the rs field = 1).
  - ROTRV: sets bit 6 (the shamt field = 1).
  - BGEZ and BLTZ: opcode `000001`, with rt field `00001` and `00000` respectively.
  - SEB and SEH: opcode `011111`, bits [10:6] = `10000` and `11000` respectively, funct `100000`.
  - Unused fields are 0. Fields not defined for an op are forced to 0 regardless of the inputs.
- `Out_Addr` wraps from 2^ADDR_W−4 to 0 with no flag.

## Timing
- Reset values (asynchronous):
  - state = `IDLE`
  - `In_Ready` = 1 (combinational from state)
  - `Out_Valid` = 0
  - `Out_Instr` = 0
  - `Out_Addr` = `BASE_ADDR`
  - `Err` = 0
- Latency: request accepted in cycle N produces `Out_Valid` in cycle N+1.
- Throughput:
  - Single-word op: at most one request per 2 cycles.
  - Two-word op: at most one request per 3 cycles.
- Handshakes:
  - `Out_Valid` never drops without `Out_Ready`.
  - `In_Ready` is low throughout `EMIT1` and `EMIT2`.
- `Err` is high for exactly one cycle, in cycle N+1.
- Reset asserted mid-sequence (for example in `EMIT2`) aborts the pending word. Output returns to the reset values immediately. The first word after reset release is at `BASE_ADDR`.

## Structure
- The shared package `mips_pkg` holds:
  - the 6-bit `op_e` enum (all mnemonics, including the pseudo-op `LI`)
  - the opcode and funct constants, shared with the control decoder
  - the `NOP_WORD` constant
- One sub-module, `instr_pack`: purely combinational mapping of `{Op, fields}` to `{word1, word2, has_word2, illegal}`.
- The FSM, address counter and output registers live in `instr_encoder`.

## Test plan
- ADD with rs=1, rt=2, rd=3 and `Out_Ready` held at 1 → `0x00221820` at address 0, `Out_Valid` high for 1 cycle.
- LI with rt=8, `Imm=0x12345678` → `0x3C081234` at address 0, then `0x35085678` at address 4. `In_Ready` is low for 2 cycles.
- BEQ with rs=1, rt=2, imm=3, and `Out_Ready` low for 3 cycles → `0x10220003` held stable, then NOP `0x00000000` at address 4. Repeat with `DELAY_SLOT_NOP`=0 → no NOP.
- ROTR with rd=2, rt=3, shamt=4 → `0x00231102`. J with `Target=0x100` → `0x08000100`.
- Unknown Op → `Err` pulses 1 cycle, no `Out_Valid`, and the next valid op is emitted at the unchanged address.
- With `ADDR_W`=4, emit 5 words → addresses 0, 4, 8, 12, 0. Assert reset during the `EMIT2` of an LI → `Out_Valid`=0 immediately, and the next word is emitted at `BASE_ADDR`.
